uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter OVS, default 16, oversampling ticks per bit.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-007 rx_data  output  8  last correctly received byte; held until the next good frame.
REQ-008 rx_done  output  1  one-cycle pulse when rx_data is updated.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 Tick divisor SHALL be CLK_HZ/(BAUD*OVS) truncated (651 at defaults); bit time = OVS*divisor clocks (10416 clocks = 104.16 us).
REQ-013 The tick counter SHALL restart from zero on the cycle a start edge is detected.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY when configured).
REQ-015 IDLE -> START only on a synchronized falling edge (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-016 START: after OVS/2 ticks, sample; 0 -> DATA; 1 -> IDLE (glitch rejected, no pulse on any output).
REQ-017 DATA: sample every OVS ticks at bit centre, shift right into an 8-bit register (bit 0 first); after the 8th sample -> STOP.
REQ-018 STOP: after OVS ticks, sample; 1 -> load rx_data, pulse rx_done; 0 -> pulse frame_err, rx_data unchanged; both -> IDLE.
REQ-019 rx_done/frame_err SHALL never be high simultaneously and SHALL be high for exactly one clock.
REQ-020 rx_done SHALL assert 9.5 bit times (+0..3 clocks for synchronizer/edge detection) after the start falling edge on rx.
REQ-021 A start edge arriving in the cycle IDLE is re-entered SHALL be accepted (back-to-back frames, no gap bit required beyond the stop bit).

Reset
REQ-022 On reset low: FSM = IDLE, counters = 0, shift register = 0, synchronizer flops = 1, rx_data = 8'h00, rx_done = 0, frame_err = 0, rx_busy = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception resumes only on a new falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN: when defined, frame is 8E1; PARITY state follows DATA, samples one bit, and a parity mismatch SHALL pulse output parity_err (1 bit, reset 0) instead of rx_done, rx_data unchanged; rx_done then asserts at 10.5 bit times.
REQ-025 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port, 8N1 timing per REQ-020.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state encoding, DATA_BITS = 8, and the default CLK_HZ/BAUD/OVS constants shared with the transmitter.
REQ-027 Sub-module baud_tick_gen (parameter DIV, inputs clk/reset/clear, output one-cycle tick) SHALL generate the oversampling tick.

Verification
REQ-028 Send 8'h55 at 9600 baud -> rx_done pulse once, rx_data = 8'h55, frame_err = 0, rx_busy high ~9.5 bit times.
REQ-029 Send 8'hA5 then 8'h3C back-to-back -> two rx_done pulses ~10 bit times apart, rx_data 8'hA5 then 8'h3C.
REQ-030 Drive rx low for 3 us then high -> no rx_done, no frame_err, FSM returns to IDLE within 1 bit time.
REQ-031 Send 8'hF0 with stop bit forced low -> frame_err pulse, rx_data keeps previous value, no rx_done.
REQ-032 Assert reset low mid-DATA of 8'h81, release, send 8'h7E -> only one rx_done, rx_data = 8'h7E.
REQ-033 With UART_RX_PARITY_EN, send 8'h07 with wrong parity (0) -> parity_err pulse, no rx_done; correct parity (1) -> rx_done, rx_data = 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, data width and the
// default clock/baud/oversampling constants that are also used by the transmitter.
// The PARITY state is present only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT   = 9600;
    localparam int OVS_DEFAULT    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    // Oversampling tick divisor, truncated.
    function automatic int tick_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: free-running counter that emits a one-cycle
// tick every DIV clocks. clear restarts the count from zero.
// Ports: clk, reset (async, active-low), clear, tick (one-cycle pulse).
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
// Ports:
//   clk        system clock
//   reset      async active-low reset
//   rx         async serial line, idle high
//   rx_data    last good byte, held until the next good frame
//   rx_done    one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   parity_err one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)
//   rx_busy    high whenever the FSM is not idle
//
// state   | meaning
// IDLE    | waiting for a synchronized falling edge on rx
// START   | half a bit in, confirm the start bit is still low
// DATA    | sample 8 data bits at bit centre, LSB first
// PARITY  | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sample stop bit, report byte or framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int BAUD   = BAUD_DEFAULT,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 rx_busy
);

    localparam int DIV = tick_div(CLK_HZ, BAUD, OVS);
    localparam int TW  = $clog2(OVS + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);

    rx_state_t            state;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [2:0]           sync_vld;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 start_edge;
    logic                 last_tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    // sync_vld tracks how far real line data has propagated since reset, so the
    // reset value of the flops is never mistaken for a high-to-low transition
    // when reset releases while the line is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= '0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign start_edge = (state == ST_IDLE) && sync_vld[2] && rx_prev && !rx_sync;
    assign last_tick  = (tick_cnt == ((state == ST_START) ? HALF_LAST : FULL_LAST));
    assign rx_busy    = (state != ST_IDLE);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_edge),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                if (start_edge) begin
                    state    <= ST_START;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
            end else if (tick) begin
                if (!last_tick) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        ST_START: state <= rx_sync ? ST_IDLE : ST_DATA;
                        ST_DATA: begin
                            shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        ST_PARITY: begin
                            // even parity: data plus parity bit has an even number of ones
                            par_bad <= rx_sync ^ (^shift);
                            state   <= ST_STOP;
                        end
`endif
                        ST_STOP: begin
                            if (!rx_sync) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                rx_data <= shift;
                                rx_done <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
